program_loader: RTL and testbench

//  Writes a program image into the 16-byte CPU RAM. This is the writer side of the memory

---
 rtl/program_loader_if.sv | 23 ++
 rtl/program_loader.sv | 145 ++++++++++++++
 tb/tb_program_loader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream and RAM write-port bundle for the program loader.
// The slave modport is the loader's view; the master modport is the feeding/observing side.
interface program_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wen;

  modport master (
    output in_valid, in_data,
    input  in_ready, ram_addr, ram_wdata, ram_wen
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ram_addr, ram_wdata, ram_wen
  );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed, checksummed program image into CPU RAM.
// The CPU is held for the whole load and released only after a good checksum.
module program_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             i_start,
  program_loader_if.slave  bus,
  output logic             o_cpu_hold,
  output logic             o_done,
  output logic             o_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  // A length field of zero stands for a full image of 2**ADDR_W bytes.
  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  state_t              w_state_next;

  logic [ADDR_W:0]     r_cnt;
  logic [ADDR_W-1:0]   r_len;
  logic [DATA_W-1:0]   r_sum;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_wen;
  logic                r_done;

  logic                w_ready;
  logic                w_accept;
  logic                w_start_ok;
  logic                w_len_bad;
  logic [ADDR_W:0]     w_len_total;
  logic [ADDR_W:0]     w_cnt_inc;
  logic                w_last;
  logic [DATA_W-1:0]   w_sum_add;

  assign w_accept    = bus.in_valid && w_ready;
  assign w_len_bad   = |bus.in_data[DATA_W-1:ADDR_W];
  assign w_len_total = (r_len == '0) ? FULL_LEN : {1'b0, r_len};
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_last      = (w_cnt_inc == w_len_total);
  assign w_sum_add   = r_sum + bus.in_data;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) w_state_next = S_LEN;
      end
      S_LEN: begin
        if (w_accept) w_state_next = w_len_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        if (w_accept && w_last) w_state_next = S_CSUM;
      end
      S_CSUM: begin
        if (w_accept) w_state_next = (bus.in_data == r_sum) ? S_DONE : S_ERR;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode: handshake, hold and error status follow the state directly
  always_comb begin
    w_ready    = 1'b0;
    w_start_ok = 1'b0;
    o_cpu_hold = 1'b0;
    o_err      = 1'b0;
    case (r_state)
      S_LEN, S_DATA, S_CSUM: begin
        w_ready    = 1'b1;
        o_cpu_hold = 1'b1;
      end
      S_ERR: begin
        w_start_ok = i_start;
        o_cpu_hold = 1'b1;
        o_err      = 1'b1;
      end
      S_IDLE, S_DONE: begin
        w_start_ok = i_start;
      end
      default: begin
        w_ready = 1'b0;
      end
    endcase
  end

  // Datapath: counters, checksum and the registered RAM write port
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt   <= '0;
      r_len   <= '0;
      r_sum   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wen   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_wen  <= 1'b0;
      r_done <= (r_state == S_CSUM) && (w_state_next == S_DONE);
      if (w_start_ok) begin
        r_cnt <= '0;
        r_sum <= '0;
      end
      if (r_state == S_LEN && w_accept && !w_len_bad) begin
        r_len <= bus.in_data[ADDR_W-1:0];
      end
      if (r_state == S_DATA && w_accept) begin
        r_addr  <= r_cnt[ADDR_W-1:0];
        r_wdata <= bus.in_data;
        r_wen   <= 1'b1;
        r_sum   <= w_sum_add;
        r_cnt   <= w_cnt_inc;
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.ram_wen   = r_wen;
  assign o_done        = r_done;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: good, full, bad-checksum, bad-length, stalled and reset loads.
module tb_program_loader;

  logic CLK = 1'b0;
  logic nRST;
  logic i_start;
  logic o_cpu_hold;
  logic o_done;
  logic o_err;

  always #5 CLK = ~CLK;

  program_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  program_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .i_start    (i_start),
    .bus        (bus),
    .o_cpu_hold (o_cpu_hold),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  int notready_cnt = 0;
  int wb, db, nb;
  logic [7:0] mem [16];
  logic [3:0] last_addr = 4'd0;

  // RAM model and event counters
  always @(posedge CLK) begin
    if (bus.ram_wen) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
      last_addr         <= bus.ram_addr;
      wr_cnt            <= wr_cnt + 1;
    end
    if (o_done) done_cnt <= done_cnt + 1;
    if (o_done && bus.ram_wen) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK); i_start = 1'b1;
    @(negedge CLK); i_start = 1'b0;
  endtask

  // Presents one byte, waits (bounded) for acceptance, then idles for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    if (!bus.in_ready) notready_cnt++;
    while (!bus.in_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("ready_wait", {31'd0, bus.in_ready}, 32'd1);
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic check_done_pulse(input string tag, input int done_base);
    chk({tag, "_done"}, {31'd0, o_done}, 32'd1);
    chk({tag, "_hold"}, {31'd0, o_cpu_hold}, 32'd0);
    chk({tag, "_err"},  {31'd0, o_err}, 32'd0);
    @(posedge CLK); #1;
    chk({tag, "_done_clr"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_done_cnt"}, done_cnt - done_base, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0;
    i_start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(negedge CLK);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_wen",   {31'd0, bus.ram_wen}, 32'd0);
    chk("rst_done",  {31'd0, o_done}, 32'd0);
    chk("rst_err",   {31'd0, o_err}, 32'd0);
    chk("rst_hold",  {31'd0, o_cpu_hold}, 32'd0);
    chk("rst_addr",  {28'd0, bus.ram_addr}, 32'd0);
    chk("rst_wdata", {24'd0, bus.ram_wdata}, 32'd0);
    @(negedge CLK); nRST = 1'b1;

    // 1: three-byte image
    wb = wr_cnt; db = done_cnt;
    pulse_start();
    chk("t1_hold_start", {31'd0, o_cpu_hold}, 32'd1);
    chk("t1_ready_start", {31'd0, bus.in_ready}, 32'd1);
    send_byte(8'h03, 0);
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 0);
    send_byte(8'hC3, 0);
    send_byte(8'h16, 0);
    chk("t1_wr_cnt", wr_cnt - wb, 32'd3);
    chk("t1_mem0", {24'd0, mem[0]}, 32'hA1);
    chk("t1_mem1", {24'd0, mem[1]}, 32'hB2);
    chk("t1_mem2", {24'd0, mem[2]}, 32'hC3);
    check_done_pulse("t1", db);

    // 2: full 16-byte image, length field 0
    wb = wr_cnt; db = done_cnt;
    pulse_start();
    send_byte(8'h00, 0);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
    send_byte(8'h78, 0);
    chk("t2_wr_cnt", wr_cnt - wb, 32'd16);
    chk("t2_last_addr", {28'd0, last_addr}, 32'd15);
    for (int i = 0; i < 16; i++) chk($sformatf("t2_mem%0d", i), {24'd0, mem[i]}, i);
    check_done_pulse("t2", db);

    // 3: bad checksum
    wb = wr_cnt; db = done_cnt;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h10, 0);
    send_byte(8'h20, 0);
    send_byte(8'h31, 0);
    chk("t3_err",  {31'd0, o_err}, 32'd1);
    chk("t3_hold", {31'd0, o_cpu_hold}, 32'd1);
    chk("t3_done", {31'd0, o_done}, 32'd0);
    @(posedge CLK); #1;
    chk("t3_err_sticky", {31'd0, o_err}, 32'd1);
    chk("t3_wr_cnt", wr_cnt - wb, 32'd2);
    chk("t3_mem0", {24'd0, mem[0]}, 32'h10);
    chk("t3_mem1", {24'd0, mem[1]}, 32'h20);
    chk("t3_done_cnt", done_cnt - db, 32'd0);

    // 4: bad length, then recovery with a good image
    wb = wr_cnt; db = done_cnt;
    pulse_start();
    chk("t4_err_clr", {31'd0, o_err}, 32'd0);
    send_byte(8'h21, 0);
    chk("t4_err",   {31'd0, o_err}, 32'd1);
    chk("t4_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t4_wen",   {31'd0, bus.ram_wen}, 32'd0);
    chk("t4_hold",  {31'd0, o_cpu_hold}, 32'd1);
    @(posedge CLK); #1;
    chk("t4_wr_cnt", wr_cnt - wb, 32'd0);
    pulse_start();
    chk("t4_err_clr2", {31'd0, o_err}, 32'd0);
    send_byte(8'h01, 0);
    send_byte(8'h5A, 0);
    send_byte(8'h5A, 0);
    chk("t4_mem0", {24'd0, mem[0]}, 32'h5A);
    check_done_pulse("t4", db);

    // 5: test 1 with 3-cycle stalls between bytes
    wb = wr_cnt; db = done_cnt; nb = notready_cnt;
    pulse_start();
    send_byte(8'h03, 3);
    chk("t5_ready_stall", {31'd0, bus.in_ready}, 32'd1);
    send_byte(8'hA1, 3);
    send_byte(8'hB2, 3);
    chk("t5_hold_stall", {31'd0, o_cpu_hold}, 32'd1);
    send_byte(8'hC3, 3);
    send_byte(8'h16, 0);
    chk("t5_wr_cnt", wr_cnt - wb, 32'd3);
    chk("t5_mem0", {24'd0, mem[0]}, 32'hA1);
    chk("t5_mem1", {24'd0, mem[1]}, 32'hB2);
    chk("t5_mem2", {24'd0, mem[2]}, 32'hC3);
    chk("t5_notready", notready_cnt - nb, 32'd0);
    check_done_pulse("t5", db);

    // 6a: start during DATA is ignored, the load completes normally
    wb = wr_cnt; db = done_cnt;
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    pulse_start();
    chk("t6a_ready", {31'd0, bus.in_ready}, 32'd1);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h66, 0);
    chk("t6a_wr_cnt", wr_cnt - wb, 32'd3);
    chk("t6a_mem1", {24'd0, mem[1]}, 32'h22);
    chk("t6a_mem2", {24'd0, mem[2]}, 32'h33);
    check_done_pulse("t6a", db);

    // 6b: asynchronous reset after the second data byte
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 0);
    chk("t6b_wen_before", {31'd0, bus.ram_wen}, 32'd1);
    nRST = 1'b0;
    #1;
    chk("t6b_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t6b_wen",   {31'd0, bus.ram_wen}, 32'd0);
    chk("t6b_done",  {31'd0, o_done}, 32'd0);
    chk("t6b_err",   {31'd0, o_err}, 32'd0);
    chk("t6b_hold",  {31'd0, o_cpu_hold}, 32'd0);
    chk("t6b_addr",  {28'd0, bus.ram_addr}, 32'd0);
    chk("t6b_wdata", {24'd0, bus.ram_wdata}, 32'd0);
    chk("t6b_mem0",  {24'd0, mem[0]}, 32'hA1);
    @(negedge CLK); nRST = 1'b1;
    @(negedge CLK);
    chk("t6b_idle_ready", {31'd0, bus.in_ready}, 32'd0);

    chk("no_done_wen_overlap", overlap_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
